cksum_engine: RTL and testbench

CKSUM_ENGINE -- requirements
Module: cksum_engine

---
 rtl/cksum_pkg.sv | 23 ++
 rtl/cksum_lane_sum.sv | 32 +++
 rtl/cksum_engine.sv | 127 ++++++++++++
 tb/tb_cksum_engine.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/cksum_pkg.sv
// Shared types and helpers for the Internet-checksum engine.
package cksum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SUM   = 2'd1,
    ST_FOLD  = 2'd2,
    ST_FINAL = 2'd3
  } cksum_state_e;

  typedef enum logic {
    MODE_GEN    = 1'b0,
    MODE_VERIFY = 1'b1
  } cksum_mode_e;

  // One's-complement fold of a 32-bit partial sum down to 16 bits.
  function automatic logic [15:0] fold16(input logic [31:0] v);
    logic [16:0] s;
    s = {1'b0, v[31:16]} + {1'b0, v[15:0]};
    return s[15:0] + {15'b0, s[16]};
  endfunction

endpackage

// File: rtl/cksum_lane_sum.sv
// Combinational per-cycle adder: LANES header bytes as big-endian 16-bit words,
// with bytes at/after the field end or past the header array forced to zero.
module cksum_lane_sum #(
  parameter int LANES       = 4,
  parameter int HDR_MAX_LEN = 64,
  parameter int ADDR_W      = 8
) (
  input  logic [HDR_MAX_LEN-1:0][7:0] hdr,
  input  logic [ADDR_W:0]             addr,
  input  logic [ADDR_W:0]             field_end,
  output logic [31:0]                 sum
);

  localparam int IW = (HDR_MAX_LEN > 1) ? $clog2(HDR_MAX_LEN) : 1;

  logic [LANES-1:0][7:0] bytes;
  logic [ADDR_W+1:0]     idx;

  always_comb begin
    bytes = '0;
    idx   = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      idx = {1'b0, addr} + (ADDR_W+2)'(k);
      if (idx < {1'b0, field_end} && idx < (ADDR_W+2)'(HDR_MAX_LEN))
        bytes[k] = hdr[idx[IW-1:0]];
    end
    sum = '0;
    for (int unsigned w = 0; w < LANES/2; w++)
      sum = sum + {16'b0, bytes[2*w], bytes[2*w+1]};
  end

endmodule

// File: rtl/cksum_engine.sv
// Multi-cycle Internet checksum generate/verify engine (IDLE->SUM->FOLD->FINAL).
// Define CKSUM_ENGINE_INCR_EN to add the RFC 1624 incremental-update request.
module cksum_engine #(
  parameter int LANES       = 4,
  parameter int HDR_MAX_LEN = 64,
  parameter int ADDR_W      = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
  input  logic                        mode_i,
  input  logic [HDR_MAX_LEN-1:0][7:0] pkt_hdr_i,
  input  logic [ADDR_W-1:0]           field_start_i,
  input  logic [ADDR_W-1:0]           field_len_i,
`ifdef CKSUM_ENGINE_INCR_EN
  input  logic                        incr_i,
  input  logic [15:0]                 old_cksum_i,
  input  logic [15:0]                 old_word_i,
  input  logic [15:0]                 new_word_i,
`endif
  output logic                        busy_o,
  output logic                        done_o,
  output logic [15:0]                 cksum_val_o,
  output logic                        cksum_ok_o
);

  import cksum_pkg::*;

  localparam int LSH = $clog2(LANES);

  cksum_state_e      state_q;
  cksum_mode_e       mode_q;
  logic [31:0]       acc_q;
  logic [ADDR_W:0]   addr_q;
  logic [ADDR_W:0]   fend_q;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   len_round;
  logic [ADDR_W:0]   n_first;
  logic [31:0]       lane_sum;
  logic [16:0]       acc_fold;
  logic [15:0]       final_fold;

  always_comb begin
    len_round  = {1'b0, field_len_i} + (ADDR_W+1)'(LANES-1);
    n_first    = len_round >> LSH;
    acc_fold   = {1'b0, acc_q[31:16]} + {1'b0, acc_q[15:0]};
    final_fold = fold16(acc_q);
  end

`ifdef CKSUM_ENGINE_INCR_EN
  logic [31:0] incr_sum;
  always_comb begin
    incr_sum = {16'b0, ~old_cksum_i} + {16'b0, ~old_word_i} + {16'b0, new_word_i};
  end
`endif

  cksum_lane_sum #(
    .LANES      (LANES),
    .HDR_MAX_LEN(HDR_MAX_LEN),
    .ADDR_W     (ADDR_W)
  ) u_lane_sum (
    .hdr      (pkt_hdr_i),
    .addr     (addr_q),
    .field_end(fend_q),
    .sum      (lane_sum)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_GEN;
      acc_q       <= '0;
      addr_q      <= '0;
      fend_q      <= '0;
      cnt_q       <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      cksum_val_o <= '0;
      cksum_ok_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            busy_o <= 1'b1;
            acc_q  <= '0;
            addr_q <= {1'b0, field_start_i};
            fend_q <= {1'b0, field_start_i} + {1'b0, field_len_i};
            cnt_q  <= n_first;
`ifdef CKSUM_ENGINE_INCR_EN
            // Incremental updates reuse FOLD/FINAL; GEN mode keeps cksum_ok_o low.
            if (incr_i) begin
              mode_q  <= MODE_GEN;
              acc_q   <= incr_sum;
              state_q <= ST_FOLD;
            end else
`endif
            begin
              mode_q  <= cksum_mode_e'(mode_i);
              state_q <= (n_first == '0) ? ST_FOLD : ST_SUM;
            end
          end
        end
        ST_SUM: begin
          acc_q  <= acc_q + lane_sum;
          addr_q <= addr_q + (ADDR_W+1)'(LANES);
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == (ADDR_W+1)'(1))
            state_q <= ST_FOLD;
        end
        ST_FOLD: begin
          acc_q   <= {15'b0, acc_fold};
          state_q <= ST_FINAL;
        end
        ST_FINAL: begin
          cksum_val_o <= ~final_fold;
          cksum_ok_o  <= (mode_q == MODE_VERIFY) && (final_fold == 16'hFFFF);
          done_o      <= 1'b1;
          busy_o      <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cksum_engine.sv
// Directed table-driven bench for cksum_engine at LANES = 4, 2 and 8.
module tb_cksum_engine;

  localparam int HM = 64;

  logic              clk;
  logic              rst;
  logic [2:0]        start_v;
  logic              mode;
  logic [HM-1:0][7:0] hdr;
  logic [7:0]        fstart;
  logic [7:0]        flen;
  logic              incr;
  logic [15:0]       old_ck, old_w, new_w;
  logic [2:0]        busy_v, done_v, ok_v;
  logic [15:0]       val_v [3];

  int n_chk = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cksum_engine #(.LANES(4), .HDR_MAX_LEN(HM), .ADDR_W(8)) u_l4 (
    .clk(clk), .rst(rst), .start_i(start_v[0]), .mode_i(mode), .pkt_hdr_i(hdr),
    .field_start_i(fstart), .field_len_i(flen),
`ifdef CKSUM_ENGINE_INCR_EN
    .incr_i(incr), .old_cksum_i(old_ck), .old_word_i(old_w), .new_word_i(new_w),
`endif
    .busy_o(busy_v[0]), .done_o(done_v[0]), .cksum_val_o(val_v[0]), .cksum_ok_o(ok_v[0]));

  cksum_engine #(.LANES(2), .HDR_MAX_LEN(HM), .ADDR_W(8)) u_l2 (
    .clk(clk), .rst(rst), .start_i(start_v[1]), .mode_i(mode), .pkt_hdr_i(hdr),
    .field_start_i(fstart), .field_len_i(flen),
`ifdef CKSUM_ENGINE_INCR_EN
    .incr_i(incr), .old_cksum_i(old_ck), .old_word_i(old_w), .new_word_i(new_w),
`endif
    .busy_o(busy_v[1]), .done_o(done_v[1]), .cksum_val_o(val_v[1]), .cksum_ok_o(ok_v[1]));

  cksum_engine #(.LANES(8), .HDR_MAX_LEN(HM), .ADDR_W(8)) u_l8 (
    .clk(clk), .rst(rst), .start_i(start_v[2]), .mode_i(mode), .pkt_hdr_i(hdr),
    .field_start_i(fstart), .field_len_i(flen),
`ifdef CKSUM_ENGINE_INCR_EN
    .incr_i(incr), .old_cksum_i(old_ck), .old_word_i(old_w), .new_word_i(new_w),
`endif
    .busy_o(busy_v[2]), .done_o(done_v[2]), .cksum_val_o(val_v[2]), .cksum_ok_o(ok_v[2]));

  typedef struct {
    string              name;
    int                 dut;
    logic               mode;
    logic [7:0]         fstart;
    logic [7:0]         flen;
    logic [HM-1:0][7:0] hdr;
    logic [15:0]        exp_val;
    logic               exp_ok;
    int                 exp_lat;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse start on one instance, then count edges until done (bounded).
  task automatic run(input int d, output int lat, output logic [15:0] val, output logic ok);
    @(negedge clk);
    start_v[d] = 1'b1;
    @(posedge clk);
    #1;
    start_v[d] = 1'b0;
    lat = 0;
    while (!done_v[d] && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    val = val_v[d];
    ok  = ok_v[d];
  endtask

  logic [HM-1:0][7:0] h_ip, h_ver, h_bad, h_odd, h_top;
  int          lat, ndone, first;
  logic [15:0] val;
  logic        ok;

  initial begin
    rst = 1'b0; start_v = '0; mode = 1'b0; hdr = '0; fstart = '0; flen = '0;
    incr = 1'b0; old_ck = '0; old_w = '0; new_w = '0;

    h_ip = '0;
    {h_ip[0], h_ip[1], h_ip[2], h_ip[3], h_ip[4], h_ip[5], h_ip[6], h_ip[7], h_ip[8], h_ip[9]} =
      80'h45_00_00_73_00_00_40_00_40_11;
    {h_ip[10], h_ip[11], h_ip[12], h_ip[13], h_ip[14], h_ip[15], h_ip[16], h_ip[17], h_ip[18], h_ip[19]} =
      80'h00_00_c0_a8_00_01_c0_a8_00_c7;
    h_ver = h_ip; h_ver[10] = 8'hb8; h_ver[11] = 8'h61;
    h_bad = h_ver; h_bad[0] = 8'h46;
    h_odd = '0; h_odd[0] = 8'h01; h_odd[1] = 8'h02; h_odd[2] = 8'h03; h_odd[3] = 8'hAA;
    h_top = '0; h_top[0] = 8'h99;
    h_top[60] = 8'h11; h_top[61] = 8'h22; h_top[62] = 8'h33; h_top[63] = 8'h44;

    #3;
    check("rst_busy", {31'b0, busy_v[0]}, 32'd0);
    check("rst_done", {31'b0, done_v[0]}, 32'd0);
    check("rst_val",  {16'b0, val_v[0]}, 32'd0);
    check("rst_ok",   {31'b0, ok_v[0]},  32'd0);
    @(negedge clk);
    rst = 1'b1;

    vecs[0] = '{"ip_gen",     0, 1'b0, 8'd0,  8'd20, h_ip,  16'hB861, 1'b0, 7};
    vecs[1] = '{"ip_verify",  0, 1'b1, 8'd0,  8'd20, h_ver, 16'h0000, 1'b1, 7};
    vecs[2] = '{"ip_corrupt", 0, 1'b1, 8'd0,  8'd20, h_bad, 16'hFEFF, 1'b0, 7};
    vecs[3] = '{"odd_len3",   0, 1'b0, 8'd0,  8'd3,  h_odd, 16'hFBFD, 1'b0, 3};
    vecs[4] = '{"len0_gen",   0, 1'b0, 8'd0,  8'd0,  h_ip,  16'hFFFF, 1'b0, 2};
    vecs[5] = '{"len0_ver",   0, 1'b1, 8'd0,  8'd0,  h_ip,  16'hFFFF, 1'b0, 2};
    vecs[6] = '{"offset12",   0, 1'b0, 8'd12, 8'd8,  h_ip,  16'h7DE6, 1'b0, 4};
    vecs[7] = '{"past_hdr",   0, 1'b0, 8'd60, 8'd8,  h_top, 16'hBB99, 1'b0, 4};
    vecs[8] = '{"ip_lanes2",  1, 1'b0, 8'd0,  8'd20, h_ip,  16'hB861, 1'b0, 12};
    vecs[9] = '{"ip_lanes8",  2, 1'b0, 8'd0,  8'd20, h_ip,  16'hB861, 1'b0, 5};

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      mode = vecs[i].mode; hdr = vecs[i].hdr; fstart = vecs[i].fstart; flen = vecs[i].flen;
      run(vecs[i].dut, lat, val, ok);
      check({vecs[i].name, "/val"}, {16'b0, val}, {16'b0, vecs[i].exp_val});
      check({vecs[i].name, "/ok"},  {31'b0, ok},  {31'b0, vecs[i].exp_ok});
      check({vecs[i].name, "/lat"}, lat, vecs[i].exp_lat);
    end

    // Second start while busy must be dropped, not queued.
    @(negedge clk);
    mode = 1'b0; hdr = h_ip; fstart = 8'd0; flen = 8'd20;
    check("busy_idle", {31'b0, busy_v[0]}, 32'd0);
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    check("busy_set", {31'b0, busy_v[0]}, 32'd1);
    ndone = 0; first = 0;
    for (int e = 1; e <= 20; e++) begin
      @(negedge clk);
      start_v[0] = (e == 2 || e == 3);
      @(posedge clk);
      #1;
      if (done_v[0]) begin
        ndone++;
        if (ndone == 1) first = e;
      end
    end
    start_v[0] = 1'b0;
    check("busy_start_dones", ndone, 1);
    check("busy_start_lat", first, 7);
    check("busy_start_val", {16'b0, val_v[0]}, 32'h0000B861);

    // Reset pulled low mid-SUM aborts without a done pulse.
    @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    @(posedge clk);
    #1;
    check("pre_rst_busy", {31'b0, busy_v[0]}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_busy", {31'b0, busy_v[0]}, 32'd0);
    check("mid_rst_done", {31'b0, done_v[0]}, 32'd0);
    check("mid_rst_val",  {16'b0, val_v[0]}, 32'd0);
    check("mid_rst_ok",   {31'b0, ok_v[0]},  32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    ndone = 0;
    for (int e = 0; e < 10; e++) begin
      @(posedge clk);
      #1;
      if (done_v[0]) ndone++;
    end
    check("post_rst_no_done", ndone, 0);
    run(0, lat, val, ok);
    check("post_rst_val", {16'b0, val}, 32'h0000B861);
    check("post_rst_lat", lat, 7);

`ifdef CKSUM_ENGINE_INCR_EN
    @(negedge clk);
    mode = 1'b1; incr = 1'b1; old_ck = 16'hDD2F; old_w = 16'h5555; new_w = 16'h3285;
    run(0, lat, val, ok);
    incr = 1'b0;
    check("incr_val", {16'b0, val}, 32'h00000000);
    check("incr_ok",  {31'b0, ok}, 32'd0);
    check("incr_lat", lat, 2);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
